// File: rtl/memory_access_stage.sv
// MEM stage: issues data-memory accesses, stalls upstream until ack, and registers writeback/redirect results.
// Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
module memory_access_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        Reg_w_i,
  input  logic        M_to_R_i,
  input  logic        Mem_W_i,
  input  logic        Mem_Rd_i,
  input  logic        Jal_i,
  input  logic        Branch_i,
  input  logic        Jal_Alu_i,
  input  logic [31:0] Inm_result_i,
  input  logic [31:0] PC_i,
  input  logic [31:0] PC_p4_i,
  input  logic [31:0] Reg2_i,
  input  logic [31:0] ALU_result_i,
  input  logic [4:0]  RegD_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        Stall_o,
  output logic        Reg_w_o,
  output logic [4:0]  RegD_o,
  output logic [31:0] WB_data_o,
  output logic        Redirect_o,
  output logic [31:0] Redirect_pc_o,
  output logic        dmem_err_o
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        reg_w_q, reg_w_d;
  logic [4:0]  regd_q, regd_d;
  logic [31:0] wb_q, wb_d;
  logic        redir_q, redir_d;
  logic [31:0] rpc_q, rpc_d;
  logic        mem_op, complete, stall, timeout_hit;
  logic [32:0] redir_calc;

  function automatic logic [31:0] wb_select(input logic m_to_r, input logic link,
                                            input logic [31:0] rdata, input logic [31:0] pc_p4,
                                            input logic [31:0] alu);
    if (m_to_r)    return rdata;
    else if (link) return pc_p4;
    else           return alu;
  endfunction

  // Returns {fire, target}; JALR beats JAL beats a taken branch.
  function automatic logic [32:0] redirect_calc(input logic jal_alu, input logic jal, input logic br,
                                                input logic [31:0] alu, input logic [31:0] pc,
                                                input logic [31:0] imm);
    if (jal_alu)                 return {1'b1, alu[31:1], 1'b0};
    else if (jal)                return {1'b1, pc + imm};
    else if (br && alu == 32'd0) return {1'b1, pc + imm};
    else                         return {1'b0, 32'd0};
  endfunction

  assign mem_op     = Mem_Rd_i | Mem_W_i;
  assign redir_calc = redirect_calc(Jal_Alu_i, Jal_i, Branch_i, ALU_result_i, PC_i, Inm_result_i);

`ifdef DMEM_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       err_q;

  assign timeout_hit = (state_q == ACCESS) && (cnt_q == 4'd15) && !dmem_ack_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ACCESS && !dmem_ack_i) ? cnt_q + 4'd1 : 4'd0;
      err_q <= timeout_hit;
    end
  end

  assign dmem_err_o = err_q;
`else
  assign timeout_hit = 1'b0;
  assign dmem_err_o  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    reg_w_d  = 1'b0;
    regd_d   = regd_q;
    wb_d     = wb_q;
    redir_d  = 1'b0;
    rpc_d    = rpc_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          addr_d  = ALU_result_i;
          wdata_d = Reg2_i;
          we_d    = Mem_W_i & ~Mem_Rd_i;
          state_d = ACCESS;
        end else begin
          complete = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem_ack_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      reg_w_d = Reg_w_i;
      regd_d  = RegD_i;
      wb_d    = wb_select(M_to_R_i, Jal_i | Jal_Alu_i, dmem_rdata_i, PC_p4_i, ALU_result_i);
      redir_d = redir_calc[32];
      if (redir_calc[32]) rpc_d = redir_calc[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      reg_w_q <= 1'b0;
      regd_q  <= 5'd0;
      wb_q    <= 32'd0;
      redir_q <= 1'b0;
      rpc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      reg_w_q <= reg_w_d;
      regd_q  <= regd_d;
      wb_q    <= wb_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
    end
  end

  assign dmem_req_o    = (state_q == ACCESS);
  assign dmem_we_o     = we_q & (state_q == ACCESS);
  assign dmem_addr_o   = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign Stall_o       = stall;
  assign Reg_w_o       = reg_w_q;
  assign RegD_o        = regd_q;
  assign WB_data_o     = wb_q;
  assign Redirect_o    = redir_q;
  assign Redirect_pc_o = rpc_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: transaction-level model checked every cycle plus literal checks.
module tb_memory_access_stage;
  logic        clk = 1'b0;
  logic        reset_i;
  logic        Reg_w_i, M_to_R_i, Mem_W_i, Mem_Rd_i, Jal_i, Branch_i, Jal_Alu_i;
  logic [31:0] Inm_result_i, PC_i, PC_p4_i, Reg2_i, ALU_result_i;
  logic [4:0]  RegD_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        Stall_o, Reg_w_o, Redirect_o, dmem_err_o;
  logic [4:0]  RegD_o;
  logic [31:0] WB_data_o, Redirect_pc_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk_i(clk), .reset_i(reset_i),
    .Reg_w_i(Reg_w_i), .M_to_R_i(M_to_R_i), .Mem_W_i(Mem_W_i), .Mem_Rd_i(Mem_Rd_i),
    .Jal_i(Jal_i), .Branch_i(Branch_i), .Jal_Alu_i(Jal_Alu_i),
    .Inm_result_i(Inm_result_i), .PC_i(PC_i), .PC_p4_i(PC_p4_i), .Reg2_i(Reg2_i),
    .ALU_result_i(ALU_result_i), .RegD_i(RegD_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .Stall_o(Stall_o), .Reg_w_o(Reg_w_o), .RegD_o(RegD_o), .WB_data_o(WB_data_o),
    .Redirect_o(Redirect_o), .Redirect_pc_o(Redirect_pc_o), .dmem_err_o(dmem_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: an instruction retires when it has no memory op,
  // or when it is waiting on memory and ack arrives; a wait of 16 cycles gives up.
  bit          m_busy;
  int          m_wait;
  logic        e_regw, e_redir, e_err;
  logic [4:0]  e_regd;
  logic [31:0] e_wb, e_rpc;
  wire m_memop = Mem_Rd_i | Mem_W_i;
  wire m_done  = !m_memop || (m_busy && dmem_ack_i);
`ifdef DMEM_TIMEOUT_EN
  wire m_timed = m_busy && !dmem_ack_i && (m_wait == 15);
`else
  wire m_timed = 1'b0;
`endif
  wire m_stall = m_memop && !m_done && !m_timed;

  always @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      m_busy <= 1'b0; m_wait <= 0;
      e_regw <= 1'b0; e_regd <= 5'd0; e_wb <= 32'd0;
      e_redir <= 1'b0; e_rpc <= 32'd0; e_err <= 1'b0;
    end else begin
      e_err  <= m_timed;
      m_busy <= !(m_done || m_timed);
      m_wait <= (m_busy && !dmem_ack_i && !m_timed) ? m_wait + 1 : 0;
      if (m_done) begin
        e_regw <= Reg_w_i;
        e_regd <= RegD_i;
        e_wb   <= M_to_R_i ? dmem_rdata_i : ((Jal_i || Jal_Alu_i) ? PC_p4_i : ALU_result_i);
        if (Jal_Alu_i) begin
          e_redir <= 1'b1; e_rpc <= ALU_result_i & 32'hFFFF_FFFE;
        end else if (Jal_i || (Branch_i && ALU_result_i == 0)) begin
          e_redir <= 1'b1; e_rpc <= PC_i + Inm_result_i;
        end else begin
          e_redir <= 1'b0;
        end
      end else begin
        e_regw  <= 1'b0;
        e_redir <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_i && cmp_en) begin
      chk("m_stall", Stall_o, m_stall);
      chk("m_req", dmem_req_o, m_busy);
      if (m_busy) begin
        chk("m_addr", dmem_addr_o, ALU_result_i);
        chk("m_we", dmem_we_o, Mem_W_i & ~Mem_Rd_i);
        chk("m_wdata", dmem_wdata_o, Reg2_i);
      end
      chk("m_regw", Reg_w_o, e_regw);
      chk("m_regd", RegD_o, e_regd);
      chk("m_wb", WB_data_o, e_wb);
      chk("m_redir", Redirect_o, e_redir);
      chk("m_rpc", Redirect_pc_o, e_rpc);
      chk("m_err", dmem_err_o, e_err);
    end
  end

  task automatic clear_inputs();
    Reg_w_i = 0; M_to_R_i = 0; Mem_W_i = 0; Mem_Rd_i = 0; Jal_i = 0; Branch_i = 0; Jal_Alu_i = 0;
    Inm_result_i = 0; PC_i = 0; PC_p4_i = 0; Reg2_i = 0; ALU_result_i = 0; RegD_i = 0;
    dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int stalls;

  initial begin
    clear_inputs();
    reset_i = 1'b0;
    #12;
    chk("rst_req", dmem_req_o, 0);
    chk("rst_we", dmem_we_o, 0);
    chk("rst_regw", Reg_w_o, 0);
    chk("rst_regd", RegD_o, 0);
    chk("rst_wb", WB_data_o, 0);
    chk("rst_redir", Redirect_o, 0);
    chk("rst_rpc", Redirect_pc_o, 0);
    chk("rst_addr", dmem_addr_o, 0);
    chk("rst_err", dmem_err_o, 0);
    cyc(1);
    reset_i = 1'b1;
    cmp_en  = 1'b1;
    cyc(1);

    // ALU op
    Reg_w_i = 1; RegD_i = 5; ALU_result_i = 32'h40;
    chk("alu_stall", Stall_o, 0);
    cyc(1);
    chk("alu_regw", Reg_w_o, 1);
    chk("alu_regd", RegD_o, 5);
    chk("alu_wb", WB_data_o, 32'h40);
    clear_inputs();
    cyc(1);

    // Load, ack in the fourth ACCESS cycle
    Mem_Rd_i = 1; M_to_R_i = 1; Reg_w_i = 1; RegD_i = 7; ALU_result_i = 32'h100;
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (Stall_o) stalls++;
      if (i == 1) begin
        chk("ld_addr", dmem_addr_o, 32'h100);
        chk("ld_we", dmem_we_o, 0);
      end
      @(posedge clk); #1;
      if (i == 3) begin dmem_ack_i = 1; dmem_rdata_i = 32'hDEADBEEF; end
    end
    chk("ld_stalls", stalls, 4);
    chk("ld_wb", WB_data_o, 32'hDEADBEEF);
    chk("ld_regw", Reg_w_o, 1);
    chk("ld_regd", RegD_o, 7);
    clear_inputs();
    cyc(1);

    // Store, immediate ack
    Mem_W_i = 1; Reg2_i = 32'h1234_5678; ALU_result_i = 32'h200; dmem_ack_i = 1;
    cyc(1);
    chk("st_req", dmem_req_o, 1);
    chk("st_we", dmem_we_o, 1);
    chk("st_wdata", dmem_wdata_o, 32'h1234_5678);
    chk("st_addr", dmem_addr_o, 32'h200);
    chk("st_stall", Stall_o, 0);
    cyc(1);
    chk("st_regw", Reg_w_o, 0);
    chk("st_req_after", dmem_req_o, 0);
    clear_inputs();
    cyc(1);

    // Read and write together: read wins
    Mem_Rd_i = 1; Mem_W_i = 1; M_to_R_i = 1; Reg_w_i = 1; RegD_i = 3;
    Reg2_i = 32'hAAAA_5555; ALU_result_i = 32'h80;
    cyc(1);
    chk("rw_we", dmem_we_o, 0);
    dmem_ack_i = 1; dmem_rdata_i = 32'h0BAD_F00D;
    cyc(1);
    chk("rw_wb", WB_data_o, 32'h0BAD_F00D);
    clear_inputs();
    cyc(1);

    // Branch taken, then not taken
    Branch_i = 1; ALU_result_i = 0; PC_i = 32'h1000; Inm_result_i = 32'hFFFF_FFF0;
    cyc(1);
    chk("br_redir", Redirect_o, 1);
    chk("br_rpc", Redirect_pc_o, 32'h0000_0FF0);
    ALU_result_i = 1;
    cyc(1);
    chk("br_nt_redir", Redirect_o, 0);
    clear_inputs();
    cyc(1);

    // JAL with target wrap-around
    Jal_i = 1; Reg_w_i = 1; RegD_i = 1; PC_i = 32'hFFFF_FFF0; Inm_result_i = 32'h20;
    PC_p4_i = 32'hFFFF_FFF4; ALU_result_i = 32'h77;
    cyc(1);
    chk("jal_rpc", Redirect_pc_o, 32'h10);
    chk("jal_wb", WB_data_o, 32'hFFFF_FFF4);
    clear_inputs();
    cyc(1);
    chk("jal_pulse", Redirect_o, 0);

    // JALR beats JAL
    Jal_Alu_i = 1; Jal_i = 1; Reg_w_i = 1; RegD_i = 1; ALU_result_i = 32'h305;
    PC_p4_i = 32'h44; PC_i = 32'h2000; Inm_result_i = 32'h8;
    cyc(1);
    chk("jalr_redir", Redirect_o, 1);
    chk("jalr_rpc", Redirect_pc_o, 32'h304);
    chk("jalr_wb", WB_data_o, 32'h44);
    clear_inputs();
    cyc(1);

`ifdef DMEM_TIMEOUT_EN
    // Load that is never acknowledged
    Mem_Rd_i = 1; M_to_R_i = 1; Reg_w_i = 1; RegD_i = 4; ALU_result_i = 32'h400;
    stalls = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (Stall_o) stalls++;
      @(posedge clk); #1;
    end
    chk("to_stalls", stalls, 16);
    chk("to_err", dmem_err_o, 1);
    chk("to_regw", Reg_w_o, 0);
    chk("to_req", dmem_req_o, 0);
    clear_inputs();
    cyc(1);
    chk("to_err_pulse", dmem_err_o, 0);
`endif

    // Reset in the middle of an access
    Mem_Rd_i = 1; M_to_R_i = 1; Reg_w_i = 1; RegD_i = 9; ALU_result_i = 32'h300;
    cyc(2);
    chk("mr_req_before", dmem_req_o, 1);
    cmp_en  = 1'b0;
    reset_i = 1'b0;
    #1;
    chk("mr_req", dmem_req_o, 0);
    chk("mr_regw", Reg_w_o, 0);
    chk("mr_wb", WB_data_o, 0);
    clear_inputs();
    cyc(1);
    reset_i = 1'b1;
    cmp_en  = 1'b1;
    cyc(2);
    chk("mr_regw_after", Reg_w_o, 0);
    chk("mr_req_after", dmem_req_o, 0);
    cyc(1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
